// File: rtl/wptr_full_burst_if.sv
// rtl/wptr_full_burst_if.sv - write-side FIFO pointer/flag bundle between the writer and wptr_full_burst
interface wptr_full_burst_if #(
    parameter int ADDRSIZE = 4,
    parameter int MAXINC   = 4
);
    localparam int INCW = $clog2(MAXINC + 1);

    logic [INCW-1:0]     winc_n;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic [ADDRSIZE:0]   afull_thresh;
    logic                clr_ovf;
    logic [INCW-1:0]     waccept;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                awfull;
    logic [ADDRSIZE:0]   wlevel;
    logic                wovf;

    modport master (
        output winc_n, wq2_rptr, afull_thresh, clr_ovf,
        input  waccept, waddr, wptr, wfull, awfull, wlevel, wovf
    );

    modport slave (
        input  winc_n, wq2_rptr, afull_thresh, clr_ovf,
        output waccept, waddr, wptr, wfull, awfull, wlevel, wovf
    );
endinterface

// File: rtl/wptr_full_burst.sv
// rtl/wptr_full_burst.sv - burst-capable write pointer, level, almost-full and overflow generator
module wptr_full_burst #(
    parameter int ADDRSIZE = 4,
    parameter int MAXINC   = 4
) (
    input  logic              wclk,
    input  logic              wrst,
    wptr_full_burst_if.slave  bus
);
    localparam int INCW  = $clog2(MAXINC + 1);
    localparam int PW    = ADDRSIZE + 1;
    localparam int DEPTH = 1 << ADDRSIZE;

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wfull_q, wfull_d;
    logic          awfull_q, awfull_d;
    logic          wovf_q, wovf_d;

    logic [PW-1:0] rbin;
    logic [PW-1:0] lvl;
    logic [PW-1:0] space;
    logic [PW-1:0] req;
    logic [PW-1:0] acc;
    logic [PW-1:0] wbinnext;
    logic [PW-1:0] nlvl;
    logic          drop;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(bus.wq2_rptr >> i);
        end
    end

    always_comb begin
        lvl      = wbin_q - rbin;
        space    = (lvl > PW'(DEPTH)) ? '0 : PW'(DEPTH) - lvl;
        req      = (PW'(bus.winc_n) > PW'(MAXINC)) ? PW'(MAXINC) : PW'(bus.winc_n);
        // Acceptance uses live space so the RAM can never be overrun.
        acc      = wrst ? '0 : ((req < space) ? req : space);
        wbinnext = wbin_q + acc;
        nlvl     = wbinnext - rbin;
        drop     = PW'(bus.winc_n) > acc;
    end

    always_comb begin
        wbin_d   = wbinnext;
        wptr_d   = wbinnext ^ (wbinnext >> 1);
        wlevel_d = nlvl;
        wfull_d  = (nlvl == PW'(DEPTH));
        awfull_d = (nlvl >= bus.afull_thresh);
        wovf_d   = wovf_q;
        if (drop) begin
            wovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            wovf_d = 1'b0;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            awfull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            awfull_q <= awfull_d;
            wovf_q   <= wovf_d;
        end
    end

    assign bus.waccept = acc[INCW-1:0];
    assign bus.waddr   = wbin_q[ADDRSIZE-1:0];
    assign bus.wptr    = wptr_q;
    assign bus.wlevel  = wlevel_q;
    assign bus.wfull   = wfull_q;
    assign bus.awfull  = awfull_q;
    assign bus.wovf    = wovf_q;
endmodule
